seg_scan_drv: RTL
=================

Name: seg_scan_drv

Overview:
- Display-side consumer of the digit-select scan interface: `sel[1:0]` and `pls_sel` come from the scan/select generator.
- Drives a 4-digit common-anode 7-segment display (active-low anodes, segments, DP) from four 4-bit digit codes.
- Inserts an anti-ghosting dead time on every digit switch.
- Snapshots the digit data once per scan frame, so one frame never mixes old and new values.
- Sits between the stopwatch/clock counters and the board pins.

Parameters:
- DEAD_CYC, 100, clk cycles all anodes are held off after each `sel` change (1 us at 100 MHz); legal range 1..2^CNT_W-1.
- CNT_W, 8, width of the dead-time counter.

Ports:
- clk  in  1  100 MHz system clock
- rst  in  1  asynchronous, active-low reset
- sel  in  2  digit index from scan generator (0 = rightmost digit)
- pls_sel  in  1  scan-rate square wave, used for DP blink
- digits  in  16  four 4-bit codes; [3:0] = digit 0 ... [15:12] = digit 3
- dp_mask  in  4  per-digit decimal-point enable
- an  out  4  anode enables, active-low, at most one low
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low
- dp  out  1  decimal point, active-low
- frame_tick  out  1  one-cycle pulse when a new snapshot is taken

Behaviour:
- Reset (`rst`=0, async):
  - an=4'b1111, seg=7'h7F, dp=1, frame_tick=0.
  - state=BLANK, cnt=DEAD_CYC-1, sel_q=0, snapshot=16'h0000.
- `sel_q` registers `sel` every clock. A change is any edge where sel != sel_q.
- States:
  - BLANK: an=1111, seg=7'h7F, dp=1.
    - cnt decrements each clock.
    - At the edge where cnt==0: go to SHOW, drive outputs for sel_q.
  - SHOW: an[sel_q]=0, all other anodes 1; seg=decode(snapshot nibble sel_q); dp as below.
  - Change detected in either state: next edge enters BLANK, cnt=DEAD_CYC-1, outputs blanked.
    - Anodes are therefore off for exactly DEAD_CYC clocks after the change edge.
    - A further change during BLANK restarts the count.
- Snapshot and frame_tick:
  - On a change edge where the new sel==0: snapshot <= digits, and frame_tick=1 for that one cycle.
  - At any other time the snapshot holds its value.
  - The first frame after reset shows the reset snapshot (0000) until sel first returns to 0.
- Decode, hex, active-low {g..a}:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- DP: dp = ~(dp_mask[sel_q] & pls_sel) in SHOW, so an enabled point blinks at the `pls_sel` rate; dp=1 in BLANK.
- Outputs are registered: no combinational path from any input to any output.
- Mid-operation reset: outputs go to reset values immediately (async assert); operation resumes in BLANK after release.

Optional Feature:
- Macro: SEG_LZ_BLANK_EN.
- Defined:
  - Leading-zero suppression on the snapshot: digit 3 is blanked if its code is 0.
  - Digit 2 is blanked if it and digit 3 are 0.
  - Digit 1 is blanked if it, digit 2 and digit 3 are 0.
  - Digit 0 is never suppressed.
  - A suppressed digit gives seg=7'h7F with its anode still driven low; DP is unaffected.
- Undefined: every digit is always decoded; the suppression logic is absent.

Test Plan:
- Reset held, then released with sel=0 static, DEAD_CYC=100 → an=1111 for 100 clk, then an=1110, seg=7'h40 (snapshot 0000).
- digits=16'h5A81, sel stepped 0→1→2→3, `pls_sel`=0 → frame_tick pulses once at the 0 entry; per digit: an=1110/1101/1011/0111, seg=79/00/08/12 respectively.
- sel changes, then changes again 40 clk later → anodes stay 1111 for 40+100 clk after the first change, never two anodes low.
- digits updated to 16'h1234 while sel=2 → display keeps old values until sel returns to 0, then shows 4,3,2,1 on digits 0..3.
- dp_mask=4'b0100, `pls_sel` toggling, sel=2 in SHOW → dp follows ~`pls_sel`; at sel=1, dp=1.
- With SEG_LZ_BLANK_EN, digits=16'h0050 → digits 3 and 2 give seg=7F, digit 1 gives 12, digit 0 gives 40. Without the macro, digits 3 and 2 give 40.

Source files
------------

// File: rtl/seg_scan_drv.sv
// seg_scan_drv: drives a 4-digit common-anode 7-segment display from the
// digit-select scan interface, with a dead time on every digit switch and a
// once-per-frame snapshot of the digit data.
//
// State table
//   state | meaning
//   BLANK | all anodes off; dead-time counter running down to zero
//   SHOW  | anode for sel_q on; segments/DP decoded from the snapshot
//
// Ports
//   clk        in   system clock (100 MHz)
//   rst        in   asynchronous reset, active low
//   sel[1:0]   in   digit index from the scan generator (0 = rightmost)
//   pls_sel    in   scan-rate square wave, blinks enabled decimal points
//   digits     in   four 4-bit codes, [3:0] = digit 0 .. [15:12] = digit 3
//   dp_mask    in   per-digit decimal-point enable
//   an         out  anode enables, active low, at most one low
//   seg        out  segments {g,f,e,d,c,b,a}, active low
//   dp         out  decimal point, active low
//   frame_tick out  one-cycle pulse when a new snapshot is taken
//
// Build option
//   SEG_LZ_BLANK_EN  when defined, leading zeros of the snapshot (digits
//                    3..1) are suppressed: segments off, anode still driven.
module seg_scan_drv #(
  parameter int DEAD_CYC = 100,
  parameter int CNT_W    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  sel,
  input  logic        pls_sel,
  input  logic [15:0] digits,
  input  logic [3:0]  dp_mask,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_tick
);

  typedef enum logic [0:0] {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEAD_CYC - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       sel_q;
  logic [15:0]      snapshot;
  logic             change;
  logic             new_frame;
  logic [3:0]       nib;
  logic [3:0]       an_d;
  logic [6:0]       seg_d;
  logic             dp_d;

  function automatic logic [6:0] decode(input logic [3:0] code);
    logic [6:0] s;
    case (code)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  assign change    = (sel != sel_q);
  // A frame starts when the scan arrives back at the rightmost digit.
  assign new_frame = change && (sel == 2'd0);
  assign nib       = snapshot[{sel_q, 2'b00} +: 4];

`ifdef SEG_LZ_BLANK_EN
  logic [3:0] lz_blank;
  always_comb begin
    lz_blank    = 4'b0000;
    lz_blank[3] = (snapshot[15:12] == 4'h0);
    lz_blank[2] = lz_blank[3] && (snapshot[11:8] == 4'h0);
    lz_blank[1] = lz_blank[2] && (snapshot[7:4] == 4'h0);
  end
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    an_d    = 4'b1111;
    seg_d   = 7'h7F;
    dp_d    = 1'b1;

    if (change) begin
      // Any switch, including one during the dead time, restarts the blank.
      state_d = BLANK;
      cnt_d   = CNT_LOAD;
    end else begin
      case (state_q)
        BLANK: begin
          if (cnt_q == '0) begin
            state_d = SHOW;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: state_d = SHOW;
      endcase

      // Outputs are registered, so they follow the state being entered.
      if (state_d == SHOW) begin
        an_d        = 4'b1111;
        an_d[sel_q] = 1'b0;
`ifdef SEG_LZ_BLANK_EN
        seg_d       = lz_blank[sel_q] ? 7'h7F : decode(nib);
`else
        seg_d       = decode(nib);
`endif
        dp_d        = ~(dp_mask[sel_q] & pls_sel);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= BLANK;
      cnt_q      <= CNT_LOAD;
      sel_q      <= 2'd0;
      snapshot   <= 16'h0000;
      an         <= 4'b1111;
      seg        <= 7'h7F;
      dp         <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sel_q      <= sel;
      an         <= an_d;
      seg        <= seg_d;
      dp         <= dp_d;
      frame_tick <= new_frame;
      if (new_frame) begin
        snapshot <= digits;
      end
    end
  end

endmodule
